codec_cfg_scheduler: RTL and testbench

//  Sequences the CODEC register RD/WR port of the I2C sequencer (codec_rd_en/codec_wr_en/busy).

---
 rtl/codec_pkg.sv | 21 ++
 rtl/codec_init_rom.sv | 20 ++
 rtl/codec_cfg_scheduler.sv | 119 +++++++++++
 tb/tb_codec_cfg_scheduler.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/codec_pkg.sv
// codec_pkg: shared FSM states, SSM2603 register map and init entry type for the codec unit
package codec_pkg;
  typedef enum logic [2:0] {
    INIT_LOAD, DELAY, ISSUE, WAIT_ACC, WAIT_DONE, FINISH, ABORT, READY
  } cfg_state_t;
  localparam logic [7:0] CODEC_REG_LEFT_ADC_VOL  = 8'h00;
  localparam logic [7:0] CODEC_REG_RIGHT_ADC_VOL = 8'h01;
  localparam logic [7:0] CODEC_REG_LEFT_DAC_VOL  = 8'h02;
  localparam logic [7:0] CODEC_REG_RIGHT_DAC_VOL = 8'h03;
  localparam logic [7:0] CODEC_REG_ANALOG_PATH   = 8'h04;
  localparam logic [7:0] CODEC_REG_DIGITAL_PATH  = 8'h05;
  localparam logic [7:0] CODEC_REG_POWER_MGMT    = 8'h06;
  localparam logic [7:0] CODEC_REG_DIGITAL_IF    = 8'h07;
  localparam logic [7:0] CODEC_REG_SAMPLING_RATE = 8'h08;
  localparam logic [7:0] CODEC_REG_ACTIVE        = 8'h09;
  localparam logic [7:0] CODEC_REG_RESET         = 8'h0F;
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } init_entry_t;
endpackage

// File: rtl/codec_init_rom.sv
// codec_init_rom: SSM2603 power-up register table, index to {addr,data}, zero when out of range
module codec_init_rom import codec_pkg::*; (
  input  logic [4:0]  idx,
  output init_entry_t entry
);
  always_comb
    case (idx)
      5'd0:    entry = '{CODEC_REG_RESET,         8'h00};
      5'd1:    entry = '{CODEC_REG_POWER_MGMT,    8'h30};
      5'd2:    entry = '{CODEC_REG_LEFT_ADC_VOL,  8'h17};
      5'd3:    entry = '{CODEC_REG_RIGHT_ADC_VOL, 8'h17};
      5'd4:    entry = '{CODEC_REG_LEFT_DAC_VOL,  8'h79};
      5'd5:    entry = '{CODEC_REG_RIGHT_DAC_VOL, 8'h79};
      5'd6:    entry = '{CODEC_REG_ANALOG_PATH,   8'h10};
      5'd7:    entry = '{CODEC_REG_DIGITAL_PATH,  8'h00};
      5'd8:    entry = '{CODEC_REG_DIGITAL_IF,    8'h02};
      5'd9:    entry = '{CODEC_REG_ACTIVE,        8'h01};
      default: entry = '0;
    endcase
endmodule

// File: rtl/codec_cfg_scheduler.sv
// codec_cfg_scheduler: replays the SSM2603 init table, then arbitrates host register
// transactions onto the single I2C sequencer RD/WR port.
module codec_cfg_scheduler import codec_pkg::*; #(
  parameter int NUM_INIT_ENTRIES = 10,
  parameter int DELAY_INDEX      = 9,
  parameter int DELAY_CYCLES     = 1000000,
  parameter int TIMEOUT_CYCLES   = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_start,
  output logic       init_done,
  output logic       init_error,
  input  logic       host_req,
  input  logic       host_we,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic       host_ack,
  output logic [7:0] host_rdata,
  output logic       host_err,
  output logic       codec_rd_en,
  output logic       codec_wr_en,
  output logic [7:0] codec_reg_addr,
  output logic [7:0] codec_data_in,
  input  logic [7:0] codec_data_out,
  input  logic       codec_data_out_valid,
  input  logic       controller_busy
);
  localparam int DW = $clog2(DELAY_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  cfg_state_t state;
  logic [4:0] idx;
  logic [DW-1:0] dcnt;
  logic [TW-1:0] tcnt;
  logic delay_ran, host_src, we;
  init_entry_t entry;
  codec_init_rom u_rom (.idx(idx), .entry(entry));
  assign host_ack = host_src && (state == FINISH || state == ABORT);
  assign host_err = host_src && state == ABORT;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state          <= INIT_LOAD;
      idx            <= '0;
      dcnt           <= '0;
      tcnt           <= '0;
      delay_ran      <= 1'b0;
      host_src       <= 1'b0;
      we             <= 1'b0;
      init_done      <= 1'b0;
      init_error     <= 1'b0;
      host_rdata     <= '0;
      codec_rd_en    <= 1'b0;
      codec_wr_en    <= 1'b0;
      codec_reg_addr <= '0;
      codec_data_in  <= '0;
    end else begin
      codec_wr_en <= state == ISSUE && we;
      codec_rd_en <= state == ISSUE && !we;
      case (state)
        // the entry is latched here even when the settle delay runs first
        INIT_LOAD: begin
          host_src       <= 1'b0;
          we             <= 1'b1;
          codec_reg_addr <= entry.addr;
          codec_data_in  <= entry.data;
          dcnt           <= '0;
          state          <= (idx == 5'(DELAY_INDEX) && !delay_ran) ? DELAY : ISSUE;
        end
        DELAY:
          if (dcnt == DW'(DELAY_CYCLES - 1)) begin
            delay_ran <= 1'b1;
            state     <= ISSUE;
          end else dcnt <= dcnt + 1'b1;
        ISSUE: begin
          tcnt  <= '0;
          state <= WAIT_ACC;
        end
        WAIT_ACC:
          if (controller_busy) begin
            tcnt  <= '0;
            state <= WAIT_DONE;
          end else if (tcnt == TW'(TIMEOUT_CYCLES)) state <= ABORT;
          else tcnt <= tcnt + 1'b1;
        WAIT_DONE: begin
          if (codec_data_out_valid && host_src && !we) host_rdata <= codec_data_out;
          if (!controller_busy) state <= FINISH;
          else if (tcnt == TW'(TIMEOUT_CYCLES)) state <= ABORT;
          else tcnt <= tcnt + 1'b1;
        end
        FINISH, ABORT: begin
          if (state == ABORT && !host_src) init_error <= 1'b1;
          if (host_src) state <= READY;
          else begin
            idx <= idx + 1'b1;
            if (idx == 5'(NUM_INIT_ENTRIES - 1)) begin
              init_done <= 1'b1;
              state     <= READY;
            end else state <= INIT_LOAD;
          end
        end
        READY:
          if (init_start) begin
            init_done  <= 1'b0;
            init_error <= 1'b0;
            idx        <= '0;
            delay_ran  <= 1'b0;
            state      <= INIT_LOAD;
          end else if (host_req) begin
            host_src       <= 1'b1;
            we             <= host_we;
            codec_reg_addr <= host_addr;
            codec_data_in  <= host_wdata;
            if (!host_we) host_rdata <= '0;
            state          <= ISSUE;
          end
        default: state <= INIT_LOAD;
      endcase
    end
endmodule

// File: tb/tb_codec_cfg_scheduler.sv
// tb_codec_cfg_scheduler: randomized host traffic against a behavioural I2C sequencer model
// and a transaction-level expectation of the init table and host results.
module tb_codec_cfg_scheduler;
  localparam int DLY = 40;
  localparam int TMO = 60;
  logic clk = 0, reset = 1, init_start = 0, host_req = 0, host_we = 0;
  logic [7:0] host_addr = 0, host_wdata = 0, codec_data_out = 0;
  logic codec_data_out_valid = 0, controller_busy = 0;
  logic init_done, init_error, host_ack, host_err, codec_rd_en, codec_wr_en;
  logic [7:0] host_rdata, codec_reg_addr, codec_data_in;
  int n_chk = 0, n_fail = 0, cyc = 0;
  typedef struct {logic wr; logic [7:0] addr; logic [7:0] data; int cyc;} rec_t;
  rec_t trace[$];
  int t = -1, mute_n = -1, fall_cyc = 0;
  logic [7:0] rd_value = 0, last_rd = 0;
  logic [15:0] tab [10] = '{16'h0F00, 16'h0630, 16'h0017, 16'h0117, 16'h0279,
                            16'h0379, 16'h0410, 16'h0500, 16'h0702, 16'h0901};

  codec_cfg_scheduler #(
    .NUM_INIT_ENTRIES(10), .DELAY_INDEX(9), .DELAY_CYCLES(DLY), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .init_start(init_start), .init_done(init_done),
    .init_error(init_error), .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata), .host_err(host_err),
    .codec_rd_en(codec_rd_en), .codec_wr_en(codec_wr_en), .codec_reg_addr(codec_reg_addr),
    .codec_data_in(codec_data_in), .codec_data_out(codec_data_out),
    .codec_data_out_valid(codec_data_out_valid), .controller_busy(controller_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // sequencer model: busy 3 cycles after a strobe for 5 cycles, read data valid mid-busy
  always @(negedge clk)
    if (!reset) begin
      t = -1;
      controller_busy = 0;
      codec_data_out_valid = 0;
    end else begin
      if (t >= 0) t++;
      if (codec_wr_en || codec_rd_en) begin
        t = (trace.size() == mute_n) ? -1 : 0;
        trace.push_back('{codec_wr_en, codec_reg_addr, codec_data_in, cyc});
      end
      if (controller_busy && !(t >= 3 && t < 8)) fall_cyc = cyc;
      controller_busy = t >= 3 && t < 8;
      codec_data_out_valid = t == 5;
      codec_data_out = (t == 5) ? rd_value : 8'h5A;
      if (t >= 8) t = -1;
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_table(input int base);
    if (trace.size() >= base + 10) begin
      for (int i = 0; i < 10; i++)
        check($sformatf("entry%0d", i), {trace[base+i].wr, trace[base+i].addr, trace[base+i].data},
              {1'b1, tab[i]});
      check("delay_gap", (trace[base+9].cyc - trace[base+8].cyc) >= DLY, 1);
      check("no_early_gap", (trace[base+8].cyc - trace[base+7].cyc) < DLY, 1);
    end
  endtask

  task automatic wait_init(input int base);
    int n = 0;
    while (!init_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("init_timeout", n < 3000, 1);
    check("init_count", trace.size() - base, 10);
    check_table(base);
  endtask

  task automatic pulse_init(input bit with_req);
    @(negedge clk);
    init_start = 1;
    if (with_req) begin
      host_req = 1;
      host_we = 1;
      host_addr = 8'h08;
      host_wdata = 8'h33;
    end
    @(negedge clk);
    init_start = 0;
    check("done_cleared", init_done, 0);
    check("err_cleared", init_error, 0);
  endtask

  task automatic host_xact(input bit we, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] rv, input bit mute);
    int base, k0, n;
    @(negedge clk);
    rd_value = rv;
    mute_n = mute ? trace.size() : -1;
    base = trace.size();
    k0 = cyc;
    host_req = 1;
    host_we = we;
    host_addr = a;
    host_wdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!host_ack && n < 500);
    host_req = 0;
    check("ack_timeout", n < 500, 1);
    if (!we) last_rd = mute ? 8'h00 : rv;
    check("host_err", host_err, mute);
    check("host_rdata", host_rdata, last_rd);
    check("strobe_count", trace.size() - base, 1);
    if (trace.size() > base) begin
      check("strobe", {trace[base].wr, trace[base].addr, trace[base].data}, {we, a, d});
      check("strobe_lat", trace[base].cyc - k0, 2);
    end
    if (!mute) check("ack_lat", cyc - fall_cyc, 1);
    mute_n = -1;
  endtask

  initial begin
    int base, n;
    #2 reset = 0;
    repeat (3) @(negedge clk);
    check("rst_strobes", {codec_wr_en, codec_rd_en, host_ack, host_err}, 0);
    check("rst_flags", {init_done, init_error}, 0);
    check("rst_data", {codec_reg_addr, codec_data_in, host_rdata}, 0);
    reset = 1;
    wait_init(0);
    check("init1_error", init_error, 0);

    host_xact(1, 8'h04, 8'h12, 8'h00, 0);
    host_xact(0, 8'h06, 8'h00, 8'hA5, 0);
    for (int i = 0; i < 10; i++)
      host_xact(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
                $urandom_range(0, 3) == 0);

    base = trace.size();
    mute_n = base + 3;
    pulse_init(0);
    wait_init(base);
    mute_n = -1;
    check("abort_error", init_error, 1);
    if (trace.size() >= base + 5)
      check("abort_gap", (trace[base+4].cyc - trace[base+3].cyc) > TMO, 1);

    base = trace.size();
    pulse_init(1);
    n = 0;
    while (!host_ack && n < 3000) begin
      @(negedge clk);
      n++;
    end
    host_req = 0;
    check("held_ack_timeout", n < 3000, 1);
    check("held_done", init_done, 1);
    check("held_err", host_err, 0);
    check_table(base);
    repeat (20) @(negedge clk);
    check("held_count", trace.size() - base, 11);
    if (trace.size() > base + 10)
      check("held_strobe", {trace[base+10].wr, trace[base+10].addr, trace[base+10].data},
            {1'b1, 8'h08, 8'h33});

    @(negedge clk);
    host_req = 1;
    host_we = 1;
    host_addr = 8'h0A;
    host_wdata = 8'h44;
    n = 0;
    while (!controller_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("busy_timeout", n < 50, 1);
    @(negedge clk);
    reset = 0;
    host_req = 0;
    #1;
    check("mid_rst_strobes", {codec_wr_en, codec_rd_en, host_ack, host_err}, 0);
    check("mid_rst_flags", {init_done, init_error}, 0);
    check("mid_rst_data", {codec_reg_addr, codec_data_in, host_rdata}, 0);
    base = trace.size();
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    last_rd = 0;
    wait_init(base);
    check("reinit_error", init_error, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
